// File: rtl/pipe_trace_buffer_if.sv
// Capture tap from the WB stage plus the registered trace read port.
interface pipe_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  logic             cap_valid;
  logic [XLEN-1:0]  cap_pc;
  logic [31:0]      cap_inst;
  logic             cap_wb_en;
  logic [REG_W-1:0] cap_wb_reg;
  logic [XLEN-1:0]  cap_wb_data;
  logic             rd_en;
  logic             rd_valid;
  logic [XLEN-1:0]  rd_pc;
  logic [31:0]      rd_inst;
  logic             rd_wb_en;
  logic [REG_W-1:0] rd_wb_reg;
  logic [XLEN-1:0]  rd_wb_data;

  modport master (
    output cap_valid, cap_pc, cap_inst, cap_wb_en, cap_wb_reg, cap_wb_data, rd_en,
    input  rd_valid, rd_pc, rd_inst, rd_wb_en, rd_wb_reg, rd_wb_data
  );
  modport slave (
    input  cap_valid, cap_pc, cap_inst, cap_wb_en, cap_wb_reg, cap_wb_data, rd_en,
    output rd_valid, rd_pc, rd_inst, rd_wb_en, rd_wb_reg, rd_wb_data
  );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Retirement trace buffer for the mips_32 pipeline: circular capture with
// free-run / PC-trigger modes, drained oldest-first through a registered port.
module pipe_trace_buffer #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              mode,
  input  logic [XLEN-1:0]   trig_pc,
  input  logic [ADDR_W:0]   post_cnt,
  pipe_trace_buffer_if.slave bus,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic              triggered,
  output logic              overflow
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [31:0]      inst;
    logic             wb_en;
    logic [REG_W-1:0] wb_reg;
    logic [XLEN-1:0]  wb_data;
  } entry_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] MAXP = (ADDR_W+1)'(DEPTH-1);

  state_t            st_q, st_d;
  entry_t            mem [DEPTH];
  entry_t            rd_ent;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, remaining, post_lat;
  logic              trig_q, ovf_q;
  logic              cap_we, trig_hit, full, rd_do;

  assign cap_we   = !arm && bus.cap_valid && (st_q == S_ARMED || st_q == S_POST);
  assign trig_hit = cap_we && st_q == S_ARMED && mode && bus.cap_pc == trig_pc;
  assign full     = count_q == FULL;
  assign rd_do    = !arm && st_q == S_DONE && bus.rd_en && count_q != '0;
  // Oldest entry sits count behind the write pointer; covers both wrapped and unwrapped fills.
  assign rd_ptr   = wr_ptr - count_q[ADDR_W-1:0];
  assign rd_ent   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) st_q <= S_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (arm) st_d = S_ARMED;
    else if (cap_we) begin
      case (st_q)
        S_ARMED: begin
          if (!mode && count_q == FULL - 1'b1) st_d = S_DONE;
          else if (trig_hit) st_d = (post_lat == '0) ? S_DONE : S_POST;
        end
        S_POST:  if (remaining == (ADDR_W+1)'(1)) st_d = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cap_we) mem[wr_ptr] <= '{bus.cap_pc, bus.cap_inst, bus.cap_wb_en, bus.cap_wb_reg, bus.cap_wb_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      count_q        <= '0;
      trig_q         <= 1'b0;
      ovf_q          <= 1'b0;
      remaining      <= '0;
      post_lat       <= '0;
      bus.rd_valid   <= 1'b0;
      bus.rd_pc      <= '0;
      bus.rd_inst    <= '0;
      bus.rd_wb_en   <= 1'b0;
      bus.rd_wb_reg  <= '0;
      bus.rd_wb_data <= '0;
    end else begin
      bus.rd_valid <= rd_do;
      if (arm) begin
        wr_ptr    <= '0;
        count_q   <= '0;
        trig_q    <= 1'b0;
        ovf_q     <= 1'b0;
        remaining <= '0;
        post_lat  <= (post_cnt > MAXP) ? MAXP : post_cnt;
      end else if (cap_we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) ovf_q   <= 1'b1;
        else      count_q <= count_q + 1'b1;
        if (trig_hit) begin
          trig_q    <= 1'b1;
          remaining <= post_lat;
        end else if (st_q == S_POST) remaining <= remaining - 1'b1;
      end else if (rd_do) begin
        count_q        <= count_q - 1'b1;
        bus.rd_pc      <= rd_ent.pc;
        bus.rd_inst    <= rd_ent.inst;
        bus.rd_wb_en   <= rd_ent.wb_en;
        bus.rd_wb_reg  <= rd_ent.wb_reg;
        bus.rd_wb_data <= rd_ent.wb_data;
      end
    end
  end

  assign state     = st_q;
  assign count     = count_q;
  assign triggered = trig_q;
  assign overflow  = ovf_q;
endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Synthesizable trace capture buffer for the mips_32 pipeline. It records one entry per retiring instruction: PC, instruction word, and write-back register/data. Entries go into a parametrised circular buffer with free-run and PC-trigger modes. The buffer is read back through a registered read port, which replaces $display-based inspection of the pipeline registers. It sits beside the MEM/WB stage and taps the WB-side signals.

Parameters:
XLEN, 32, datapath width of PC and write-back data
REG_W, 5, register index width
DEPTH, 16, number of entries; power of two, at least 2
ADDR_W, $clog2(DEPTH), pointer width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
arm  in  1  pulse: clear buffer, enter ARMED
mode  in  1  0 = stop when full; 1 = circular, stop after trigger plus post_cnt entries
trig_pc  in  XLEN  trigger PC (mode 1)
post_cnt  in  ADDR_W+1  entries to capture after the trigger entry; sampled when arm is high
cap_valid  in  1  one instruction retires this cycle
cap_pc  in  XLEN  PC of the retiring instruction
cap_inst  in  32  instruction word
cap_wb_en  in  1  register write enable
cap_wb_reg  in  REG_W  destination register
cap_wb_data  in  XLEN  write-back data
rd_en  in  1  pop the oldest entry (honoured in DONE only)
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
count  out  ADDR_W+1  valid entries held, 0..DEPTH
triggered  out  1  sticky: trigger seen since the last arm
overflow  out  1  sticky: an entry was overwritten since the last arm
rd_valid  out  1  read data valid, 1-cycle pulse
rd_pc  out  XLEN  read data fields; these hold their value between reads
rd_inst  out  32
rd_wb_en  out  1
rd_wb_reg  out  REG_W
rd_wb_data  out  XLEN

Behaviour:
- Reset: state=IDLE; count, triggered, overflow, rd_valid and all rd_* = 0; write/read pointers = 0. Memory contents are don't-care.
- arm (any state): next state=ARMED; count, pointers, triggered and overflow cleared; post_cnt latched and clamped to DEPTH-1. Priority: arm > cap_valid > rd_en. A capture or read presented in the arm cycle is dropped.
- IDLE: no captures; rd_en ignored.
- ARMED, mode 0: each cap_valid writes at wr_ptr, then wr_ptr++ and count++. When count reaches DEPTH, next state=DONE; that write is stored. Trigger logic is disabled in mode 0.
- ARMED, mode 1: each cap_valid writes at wr_ptr and wr_ptr++ (wraps modulo DEPTH). count saturates at DEPTH; a write while count==DEPTH overwrites the oldest entry and sets overflow.
- Trigger (mode 1): when cap_valid && cap_pc==trig_pc in ARMED, the entry is stored and triggered=1. If the latched post_cnt is 0, next state=DONE; otherwise next state=POST with remaining=post_cnt. Matches in POST are ignored.
- POST: each cap_valid stores an entry (same wrap and overflow rules) and decrements remaining. The write that brings remaining to 0 moves state to DONE.
- DONE: capture stops. rd_ptr = oldest entry: wr_ptr if overflow was set, else 0.
  - rd_en while count>0: rd_* loaded from mem[rd_ptr], rd_valid=1 in the next cycle, rd_ptr++, count--.
  - rd_en while count==0: rd_valid stays 0 and rd_* hold.
  - Entries are returned oldest first. The state stays DONE until arm or reset.
- Latency: capture to visible count is 1 cycle; rd_en to rd_valid is 1 cycle. Back-to-back rd_en gives one entry per cycle.
- Reset mid-capture or mid-read: immediate return to IDLE; buffer contents are abandoned.

Test Plan:
- Reset then idle: assert reset 2 cycles with cap_valid=1 -> state=0, count=0, rd_valid=0, all outputs 0.
- Mode 0, DEPTH=8: arm, then 10 captures with pc=0,4,...,36 -> DONE after the 8th capture, count=8, overflow=0. Eight rd_en pulses return pc 0..28 in order; a 9th rd_en gives rd_valid=0.
- Mode 1 trigger with wrap: trig_pc=0x40, post_cnt=2, pcs 0x00..0x60 step 4 -> triggered=1, DONE after pc 0x48, overflow=1, count=8. Readout returns 0x2C..0x48.
- Trigger with post_cnt=0: trig_pc matches the first capture -> DONE the next cycle, count=1, readout returns that pc.
- Simultaneous events: arm together with cap_valid -> count=0 the next cycle. arm in DONE during readout (rd_en=1) -> no rd_valid, state=ARMED, count=0.
- Clamp and stall: post_cnt=15 with DEPTH=8 -> exactly 7 post entries, and the trigger entry is read first. cap_valid low for 3 cycles in POST -> remaining unchanged.
